// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the supported operand-width range.
package serial_add_ctrl_pkg;

    // FSM state encoding, kept as plain 2-bit constants so the encoding is
    // visible to tools and older code that compares raw state values.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Supported WIDTH range. Below 2 there is no separate carry-into-MSB
    // bit to capture for the overflow flag.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full adder: the only arithmetic element of the serial adder.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : serial_add_ctrl_fa

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Accepts an operand pair in IDLE, then walks
// a single full adder over the operands LSB-first, one bit per clock, and
// presents the registered sum and flags in DONE until the consumer takes it.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    // Counter values for the last two bit positions: the carry out of the
    // second-to-last bit is the carry into the MSB.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic             carry_msb;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_cout;

    logic             accept;
    logic             last_bit;

    assign accept   = (state == ST_IDLE) && i_valid;
    assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

    // Handshake and status outputs decode straight from the state register.
    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state == ST_RUN);
    assign o_valid = (state == ST_DONE);
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;

    serial_add_ctrl_fa fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Control FSM: IDLE -> RUN on accept, RUN -> DONE after the MSB,
    // DONE -> IDLE when the consumer takes the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)   state <= ST_RUN;
                ST_RUN:  if (last_bit) state <= ST_DONE;
                ST_DONE: if (i_ready)  state <= ST_IDLE;
                default:               state <= ST_IDLE;
            endcase
        end
    end

    // Bit counter: cleared on accept, steps once per RUN cycle and wraps to
    // zero on the MSB so it never passes WIDTH-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (accept || last_bit) begin
            cnt <= '0;
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Serial datapath: operand shift registers feed the adder LSBs, the sum
    // bit enters the result register from the top, carry recirculates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
        end else if (accept) begin
            a_sr  <= i_a;
            b_sr  <= i_b;
            carry <= i_cin;
        end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            if (cnt == CNT_PENULT) carry_msb <= fa_cout;
        end
    end

    // Result registers: loaded only as the MSB completes, so they hold the
    // previous answer through IDLE and RUN of the next operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_bit) begin
            sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
            cout_q <= fa_cout;
            ovf_q  <= carry_msb ^ fa_cout;
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks for the bit-serial adder controller.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             o_busy;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation starting #1 after a posedge with the DUT in IDLE.
    // hold: cycles to keep i_ready low in DONE while toggling i_valid/i_a.
    // scramble: change operands every cycle while the operation is running.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input int hold, input bit scramble, input bit full);
        int lat;
        chk("ready_idle", o_ready, 1'b1);
        i_valid = 1'b1; i_a = a; i_b = b; i_cin = cin; i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (full) chk("busy_run", o_busy, 1'b1);
        lat = 0;
        while (!o_valid && lat < WIDTH + 4) begin
            if (scramble) begin
                i_a = 8'($urandom); i_b = 8'($urandom);
                i_cin = 1'($urandom); i_valid = 1'($urandom);
            end
            @(posedge i_clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        chk("latency", lat, WIDTH);
        chk("sum", o_sum, es);
        chk("cout", o_cout, ec);
        chk("ovf", o_ovf, eo);
        for (int h = 0; h < hold; h++) begin
            i_valid = ~i_valid; i_a = ~i_a;
            @(posedge i_clk); #1;
            if (full) begin
                chk("hold_valid", o_valid, 1'b1);
                chk("hold_sum", o_sum, es);
                chk("hold_ready", o_ready, 1'b0);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("valid_drop", o_valid, 1'b0);
        chk("ready_back", o_ready, 1'b1);
    endtask

    initial begin
        logic [8:0] ref_full;
        logic [7:0] ra, rb;
        logic       rc, rovf;
        int         seen;

        i_rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_sum", o_sum, 8'h00);
        chk("rst_flags", {o_cout, o_ovf}, 2'b00);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Directed vectors, expected values computed by hand.
        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        // Back-pressure in DONE with i_valid/i_a toggling.
        run_op(8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0, 5, 1'b0, 1'b1);
        // Operands changing during RUN must not disturb the result.
        run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1);

        // Reset during RUN at cnt=3: outputs clear at once, nothing emerges.
        run_op(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        i_valid = 1'b1; i_a = 8'hF0; i_b = 8'h0F; i_cin = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_sum", o_sum, 8'h00);
        chk("mid_rst_flags", {o_cout, o_ovf}, 2'b00);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        chk("no_valid_after_rst", seen, 0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Randomized regression against an arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            rovf = (ra[7] == rb[7]) && (ref_full[7] != ra[7]);
            run_op(ra, rb, rc, ref_full[7:0], ref_full[8], rovf,
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_ctrl
